jt12_slot_seq: RTL and testbench
================================

Name: jt12_slot_seq

Overview:
- Slot sequencer and connection controller for the shared FM operator datapath.
- Steps through the 24 operator slots (6 channels × 4 operators) in the order the operator pipeline expects.
- Per slot, drives the operator-entry strobes, the frame-start pulse, the per-algorithm operand-select lines and the delayed feedback level.
- Holds the per-channel algorithm/feedback register file, written from the CPU register decoder.

Parameters:
- NUM_CH, 6, channels sequenced; slots per frame = 4*NUM_CH.
- CNTW, 5, slot counter width; must satisfy 2^CNTW >= 4*NUM_CH.

Ports:
- clk  in  1  system clock; every cycle is one slot.
- rst  in  1  reset, asynchronous, active-high.
- cfg_we  in  1  write strobe for the channel config register.
- cfg_ch  in  3  target channel, 0..NUM_CH-1.
- cfg_alg  in  3  connection algorithm 0..7.
- cfg_fb  in  3  self-feedback level 0..7.
- s1_enters, s2_enters, s3_enters, s4_enters  out  1 each  operator of the slot now entering the pipeline (one-hot or all zero).
- zero  out  1  high on the first slot of each frame.
- use_prevprev1, use_internal_x, use_internal_y, use_prev2, use_prev1  out  1 each  operand selects for the slot now entering.
- fb_II  out  3  feedback level of the slot that entered one cycle earlier.
- slot_ch  out  3  channel of the slot now entering.
- slot_op  out  2  operator index now entering (0=S1, 1=S2, 2=S3, 3=S4).

Behaviour:
- Slot counter cnt, 0..23, advances every clk.
  - 23 wraps to 0.
  - Channel = cnt mod 6.
  - Group = cnt div 6; groups 0,1,2,3 map to S1, S3, S2, S4 respectively.
- All outputs are registered. Each edge loads outputs decoded from the current cnt, then cnt increments.
  - Output latency from cnt is therefore one cycle.
  - zero=1 exactly in the cycle presenting cnt=0.
- Reset (async assert) values:
  - cnt=0.
  - All s*_enters, zero and use_* = 0; fb_II=0; slot_ch=0; slot_op=0.
  - Config file: all alg=0, fb=0.
- After reset deasserts, the first edge presents slot 0: s1_enters=1, zero=1, slot_ch=0.
- Operand select decode (A = alg of the decoded channel):
  - use_prevprev1 = S1 | (S3 & A==5).
  - use_prev2 = (S3 & A<=2) | (S4 & A==3).
  - use_internal_x = S4 & A==2.
  - use_internal_y = S4 & (A==0|A==1|A==3).
  - use_prev1 = S1 | (S3 & A==1) | (S2 & A∈{0,3,4,5,6}) | (S4 & A==5).
- fb_II: one extra register stage of the decoded channel's fb, so it aligns with the pipeline's cycle-II stage of that slot.
  - Always carries fb, including on non-S1 slots; the datapath applies it only on S1.
- Config register file: NUM_CH entries of {alg,fb}.
  - Written on the clk edge with cfg_we=1.
  - cfg_ch >= NUM_CH: write ignored, no entry modified.
  - Read is combinational from the array (old data on the same edge).
  - Write and decode of the same channel on the same edge: the decode uses the old value; the new value applies from the next visit to that channel.
  - Mid-frame writes are legal. Slots of that channel already presented keep old selects; later slots use new ones, so split frames are accepted.
- Reset asserted mid-frame: everything returns to reset values immediately; the frame restarts from cnt=0 after release.

Decomposition:
- Shared package jt12_slot_pkg:
  - Slot order constants GRP_S1=0, GRP_S3=1, GRP_S2=2, GRP_S4=3.
  - Operator index encoding.
  - NUM_SLOTS=24.
  - The alg→select truth table as a constant function, reused by the operator bench model.
- One sub-module, jt12_alg_dec: purely combinational {op, alg} → five use_* bits. Instantiated once here, and also standalone in the bench for exhaustive checking.

Test Plan:
- Reset release, then 48 cycles:
  - zero high at cycles 1 and 25 only.
  - s1_enters on cycles 1-6, s3 on 7-12, s2 on 13-18, s4 on 19-24.
  - slot_ch sequence 0..5 repeats.
- Write ch2 alg=5 fb=6, then run one frame:
  - On the ch2 S3 slot: use_prevprev1=1, use_prev1=0, use_prev2=0.
  - On the ch2 S4 slot: use_prev1=1.
  - fb_II=6 exactly one cycle after the ch2 S1 slot.
- Exhaustive: all 8 algs × 4 ops through jt12_alg_dec versus the package table. Additionally, alg=7 gives all use_* zero except on S1.
- cfg_we with cfg_ch=6 and 7, alg=3: readback via decode shows all channels unchanged (alg 0).
- Write ch0 alg=2 on the same edge that decodes the ch0 S4 slot:
  - That slot still shows use_internal_y=1 (old alg 0).
  - The next frame's ch0 S4 shows use_internal_x=1, use_internal_y=0.
- Assert rst asynchronously mid-frame at cnt=14 (between clock edges):
  - All outputs 0 within the same cycle.
  - After release, the first presented slot has zero=1, s1_enters=1.

Source files
------------

// File: rtl/jt12_slot_pkg.sv
`default_nettype none
// ============================================================================
// Module  : jt12_slot_pkg
// Brief   : Slot ordering constants and operand-select truth table for the
//           FM operator slot sequencer.
// Revision: 1.0
// ============================================================================
package jt12_slot_pkg;

    localparam int NUM_SLOTS = 24;

    // Group index (cnt div NUM_CH) to operator mapping
    localparam logic [1:0] GRP_S1 = 2'd0;
    localparam logic [1:0] GRP_S3 = 2'd1;
    localparam logic [1:0] GRP_S2 = 2'd2;
    localparam logic [1:0] GRP_S4 = 2'd3;

    typedef enum logic [1:0] {
        OP_S1 = 2'd0,
        OP_S2 = 2'd1,
        OP_S3 = 2'd2,
        OP_S4 = 2'd3
    } op_e;

    localparam int SEL_PREVPREV1  = 4;
    localparam int SEL_INTERNAL_X = 3;
    localparam int SEL_INTERNAL_Y = 2;
    localparam int SEL_PREV2      = 1;
    localparam int SEL_PREV1      = 0;

    function automatic op_e grp_to_op(input logic [1:0] grp);
        op_e op;
        case (grp)
            GRP_S1:  op = OP_S1;
            GRP_S3:  op = OP_S3;
            GRP_S2:  op = OP_S2;
            default: op = OP_S4;
        endcase
        return op;
    endfunction

    function automatic logic [4:0] alg_sel(input op_e op, input logic [2:0] alg);
        logic       s1, s2, s3, s4;
        logic [4:0] sel;
        s1 = (op == OP_S1);
        s2 = (op == OP_S2);
        s3 = (op == OP_S3);
        s4 = (op == OP_S4);
        sel                 = '0;
        sel[SEL_PREVPREV1]  = s1 | (s3 & (alg == 3'd5));
        sel[SEL_PREV2]      = (s3 & (alg <= 3'd2)) | (s4 & (alg == 3'd3));
        sel[SEL_INTERNAL_X] = s4 & (alg == 3'd2);
        sel[SEL_INTERNAL_Y] = s4 & ((alg == 3'd0) | (alg == 3'd1) | (alg == 3'd3));
        sel[SEL_PREV1]      = s1 | (s3 & (alg == 3'd1)) | (s4 & (alg == 3'd5)) |
                              (s2 & ((alg == 3'd0) | (alg == 3'd3) | (alg == 3'd4) |
                                     (alg == 3'd5) | (alg == 3'd6)));
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jt12_alg_dec.sv
`default_nettype none
// ============================================================================
// Module  : jt12_alg_dec
// Brief   : Combinational {operator, algorithm} to operand-select decoder.
// Revision: 1.0
// ============================================================================
module jt12_alg_dec
    import jt12_slot_pkg::*;
(
    input  logic [1:0] op_i,
    input  logic [2:0] alg_i,
    output logic       use_prevprev1_o,
    output logic       use_internal_x_o,
    output logic       use_internal_y_o,
    output logic       use_prev2_o,
    output logic       use_prev1_o
);

    logic [4:0] w_sel;

    assign w_sel            = alg_sel(op_e'(op_i), alg_i);
    assign use_prevprev1_o  = w_sel[SEL_PREVPREV1];
    assign use_internal_x_o = w_sel[SEL_INTERNAL_X];
    assign use_internal_y_o = w_sel[SEL_INTERNAL_Y];
    assign use_prev2_o      = w_sel[SEL_PREV2];
    assign use_prev1_o      = w_sel[SEL_PREV1];

endmodule
`default_nettype wire

// File: rtl/jt12_slot_seq.sv
`default_nettype none
// ============================================================================
// Module  : jt12_slot_seq
// Brief   : Slot sequencer and per-channel connection/feedback register file
//           driving the shared FM operator pipeline.
// Revision: 1.0
// ============================================================================
module jt12_slot_seq
    import jt12_slot_pkg::*;
#(
    parameter int NUM_CH = 6,
    parameter int CNTW   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_we,
    input  logic [2:0] cfg_ch,
    input  logic [2:0] cfg_alg,
    input  logic [2:0] cfg_fb,
    output logic       s1_enters,
    output logic       s2_enters,
    output logic       s3_enters,
    output logic       s4_enters,
    output logic       zero,
    output logic       use_prevprev1,
    output logic       use_internal_x,
    output logic       use_internal_y,
    output logic       use_prev2,
    output logic       use_prev1,
    output logic [2:0] fb_II,
    output logic [2:0] slot_ch,
    output logic [1:0] slot_op
);

    localparam int SLOTS = 4 * NUM_CH;

    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [2:0]      alg_q [NUM_CH];
    logic [2:0]      fb_q  [NUM_CH];

    logic [3:0] enters_q, enters_d;
    logic       zero_q, zero_d;
    logic [4:0] sel_q, sel_d;
    logic [2:0] fbst_q, fbst_d;
    logic [2:0] fb_II_q;
    logic [2:0] ch_q;
    logic [1:0] op_q;

    logic [2:0] w_ch;
    logic [1:0] w_grp;
    op_e        w_op;
    logic [2:0] w_alg;
    logic       w_cfg_ok;

    assign w_ch     = 3'(cnt_q % CNTW'(NUM_CH));
    assign w_grp    = 2'(cnt_q / CNTW'(NUM_CH));
    assign w_op     = grp_to_op(w_grp);
    assign w_alg    = alg_q[w_ch];
    assign w_cfg_ok = cfg_we && (32'(cfg_ch) < NUM_CH);

    jt12_alg_dec u_alg_dec (
        .op_i             (w_op),
        .alg_i            (w_alg),
        .use_prevprev1_o  (sel_d[SEL_PREVPREV1]),
        .use_internal_x_o (sel_d[SEL_INTERNAL_X]),
        .use_internal_y_o (sel_d[SEL_INTERNAL_Y]),
        .use_prev2_o      (sel_d[SEL_PREV2]),
        .use_prev1_o      (sel_d[SEL_PREV1])
    );

    always_comb begin
        cnt_d    = (cnt_q == CNTW'(SLOTS - 1)) ? '0 : cnt_q + CNTW'(1);
        enters_d = 4'b0001 << w_op;
        zero_d   = (cnt_q == '0);
        fbst_d   = fb_q[w_ch];
    end

    // fbst_q is the cycle-I copy of the slot's feedback; fb_II lags it by one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            enters_q <= '0;
            zero_q   <= 1'b0;
            sel_q    <= '0;
            fbst_q   <= '0;
            fb_II_q  <= '0;
            ch_q     <= '0;
            op_q     <= '0;
        end else begin
            cnt_q    <= cnt_d;
            enters_q <= enters_d;
            zero_q   <= zero_d;
            sel_q    <= sel_d;
            fbst_q   <= fbst_d;
            fb_II_q  <= fbst_q;
            ch_q     <= w_ch;
            op_q     <= w_op;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                alg_q[i] <= '0;
                fb_q[i]  <= '0;
            end
        end else if (w_cfg_ok) begin
            alg_q[cfg_ch] <= cfg_alg;
            fb_q[cfg_ch]  <= cfg_fb;
        end
    end

    assign s1_enters      = enters_q[OP_S1];
    assign s2_enters      = enters_q[OP_S2];
    assign s3_enters      = enters_q[OP_S3];
    assign s4_enters      = enters_q[OP_S4];
    assign zero           = zero_q;
    assign use_prevprev1  = sel_q[SEL_PREVPREV1];
    assign use_internal_x = sel_q[SEL_INTERNAL_X];
    assign use_internal_y = sel_q[SEL_INTERNAL_Y];
    assign use_prev2      = sel_q[SEL_PREV2];
    assign use_prev1      = sel_q[SEL_PREV1];
    assign fb_II          = fb_II_q;
    assign slot_ch        = ch_q;
    assign slot_op        = op_q;

endmodule
`default_nettype wire

// File: tb/tb_jt12_slot_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_jt12_slot_seq
// Brief   : Scoreboard bench for the slot sequencer and the algorithm decoder.
// Revision: 1.0
// ============================================================================
module tb_jt12_slot_seq;
    import jt12_slot_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_we;
    logic [2:0] cfg_ch, cfg_alg, cfg_fb;
    logic       s1_enters, s2_enters, s3_enters, s4_enters, zero;
    logic       use_prevprev1, use_internal_x, use_internal_y, use_prev2, use_prev1;
    logic [2:0] fb_II, slot_ch;
    logic [1:0] slot_op;

    logic [1:0] dec_op;
    logic [2:0] dec_alg;
    logic [4:0] dec_sel;

    always #5 clk = ~clk;

    jt12_slot_seq #(.NUM_CH(6), .CNTW(5)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_we         (cfg_we),
        .cfg_ch         (cfg_ch),
        .cfg_alg        (cfg_alg),
        .cfg_fb         (cfg_fb),
        .s1_enters      (s1_enters),
        .s2_enters      (s2_enters),
        .s3_enters      (s3_enters),
        .s4_enters      (s4_enters),
        .zero           (zero),
        .use_prevprev1  (use_prevprev1),
        .use_internal_x (use_internal_x),
        .use_internal_y (use_internal_y),
        .use_prev2      (use_prev2),
        .use_prev1      (use_prev1),
        .fb_II          (fb_II),
        .slot_ch        (slot_ch),
        .slot_op        (slot_op)
    );

    jt12_alg_dec u_dec (
        .op_i             (dec_op),
        .alg_i            (dec_alg),
        .use_prevprev1_o  (dec_sel[4]),
        .use_internal_x_o (dec_sel[3]),
        .use_internal_y_o (dec_sel[2]),
        .use_prev2_o      (dec_sel[1]),
        .use_prev1_o      (dec_sel[0])
    );

    typedef struct packed {
        logic [3:0] en;
        logic       zero;
        logic [4:0] sel;
        logic [2:0] fb;
        logic [2:0] ch;
        logic [1:0] op;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   m_cnt;
    logic [2:0] m_alg [6];
    logic [2:0] m_fb  [6];
    logic [2:0] m_fbst;

    wire [3:0] o_en  = {s4_enters, s3_enters, s2_enters, s1_enters};
    wire [4:0] o_sel = {use_prevprev1, use_internal_x, use_internal_y, use_prev2, use_prev1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    // {prevprev1, internal_x, internal_y, prev2, prev1}, written per algorithm
    function automatic logic [4:0] model_sel(input int op, input int alg);
        logic [4:0] s;
        s = 5'b0;
        case (op)
            0: s = 5'b10001;
            1: s[0] = (alg != 1) && (alg != 2) && (alg != 7);
            2: begin
                s[4] = (alg == 5);
                s[1] = (alg < 3);
                s[0] = (alg == 1);
            end
            default: begin
                s[3] = (alg == 2);
                s[2] = (alg == 0) || (alg == 1) || (alg == 3);
                s[1] = (alg == 3);
                s[0] = (alg == 5);
            end
        endcase
        return s;
    endfunction

    task automatic model_reset();
        m_cnt  = 0;
        m_fbst = 3'd0;
        for (int i = 0; i < 6; i++) begin
            m_alg[i] = 3'd0;
            m_fb[i]  = 3'd0;
        end
        sb.delete();
    endtask

    task automatic step(input logic we, input logic [2:0] ch, input logic [2:0] alg,
                        input logic [2:0] fb);
        exp_t e, got;
        int   mch, mgrp, mop;
        @(negedge clk);
        cfg_we = we; cfg_ch = ch; cfg_alg = alg; cfg_fb = fb;
        mch  = m_cnt % 6;
        mgrp = m_cnt / 6;
        mop  = (mgrp == 0) ? 0 : (mgrp == 1) ? 2 : (mgrp == 2) ? 1 : 3;
        e.en   = 4'(1 << mop);
        e.zero = (m_cnt == 0);
        e.sel  = model_sel(mop, int'(m_alg[mch]));
        e.fb   = m_fbst;
        e.ch   = 3'(mch);
        e.op   = 2'(mop);
        sb.push_back(e);
        m_fbst = m_fb[mch];
        m_cnt  = (m_cnt + 1) % 24;
        if (we && ch < 3'd6) begin
            m_alg[ch] = alg;
            m_fb[ch]  = fb;
        end
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        cyc++;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            got = sb.pop_front();
            chk("enters", 32'(o_en), 32'(got.en));
            chk("zero", 32'(zero), 32'(got.zero));
            chk("sel", 32'(o_sel), 32'(got.sel));
            chk("fb_II", 32'(fb_II), 32'(got.fb));
            chk("slot_ch", 32'(slot_ch), 32'(got.ch));
            chk("slot_op", 32'(slot_op), 32'(got.op));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_en"}, 32'(o_en), 32'd0);
        chk({tag, "_zero"}, 32'(zero), 32'd0);
        chk({tag, "_sel"}, 32'(o_sel), 32'd0);
        chk({tag, "_fb"}, 32'(fb_II), 32'd0);
        chk({tag, "_ch"}, 32'(slot_ch), 32'd0);
        chk({tag, "_op"}, 32'(slot_op), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic run_to(input int target, input string tag);
        int n;
        n = 0;
        while (m_cnt != target && n < 30) begin
            step(1'b0, 3'd0, 3'd0, 3'd0);
            n++;
        end
        if (m_cnt != target) chk({tag, "_timeout"}, 32'(m_cnt), 32'(target));
    endtask

    initial begin
        logic prev_s1;
        rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_alg = '0; cfg_fb = '0;
        dec_op = '0; dec_alg = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("rst");
        #1 rst = 1'b0;
        cyc = 0;

        // Two full frames from reset release
        for (int i = 0; i < 48; i++) begin
            int g;
            step(1'b0, 3'd0, 3'd0, 3'd0);
            g = ((cyc - 1) % 24) / 6;
            chk("t1_zero", 32'(zero), 32'((cyc == 1) || (cyc == 25)));
            chk("t1_en", 32'(o_en), (g == 0) ? 32'h1 : (g == 1) ? 32'h4 : (g == 2) ? 32'h2 : 32'h8);
            chk("t1_ch", 32'(slot_ch), 32'((cyc - 1) % 6));
        end

        // ch2 alg=5 fb=6
        step(1'b1, 3'd2, 3'd5, 3'd6);
        prev_s1 = 1'b0;
        for (int i = 0; i < 25; i++) begin
            step(1'b0, 3'd0, 3'd0, 3'd0);
            if (prev_s1) chk("t2_fb", 32'(fb_II), 32'd6);
            if (slot_ch == 3'd2 && slot_op == 2'd2) begin
                chk("t2_s3_pp1", 32'(use_prevprev1), 32'd1);
                chk("t2_s3_p1", 32'(use_prev1), 32'd0);
                chk("t2_s3_p2", 32'(use_prev2), 32'd0);
            end
            if (slot_ch == 3'd2 && slot_op == 2'd3) chk("t2_s4_p1", 32'(use_prev1), 32'd1);
            prev_s1 = (slot_ch == 3'd2 && slot_op == 2'd0);
        end

        // Exhaustive decoder
        for (int op = 0; op < 4; op++) begin
            for (int alg = 0; alg < 8; alg++) begin
                dec_op  = 2'(op);
                dec_alg = 3'(alg);
                #1;
                chk("dec_pkg", 32'(dec_sel), 32'(alg_sel(op_e'(2'(op)), 3'(alg))));
                chk("dec_model", 32'(dec_sel), 32'(model_sel(op, alg)));
                if (alg == 7) chk("dec_alg7", 32'(dec_sel), (op == 0) ? 32'h11 : 32'h0);
            end
        end

        // Out-of-range channel writes are dropped
        do_reset();
        step(1'b1, 3'd6, 3'd3, 3'd0);
        step(1'b1, 3'd7, 3'd3, 3'd0);
        for (int i = 0; i < 24; i++) begin
            step(1'b0, 3'd0, 3'd0, 3'd0);
            if (slot_op == 2'd2) chk("t4_s3_p2", 32'(use_prev2), 32'd1);
            if (slot_op == 2'd3) chk("t4_s4_iy", 32'({use_internal_x, use_internal_y}), 32'b01);
        end

        // Write colliding with decode of the same channel
        run_to(18, "t5a");
        step(1'b1, 3'd0, 3'd2, 3'd0);
        chk("t5_slot", 32'({slot_ch, slot_op}), 32'({3'd0, 2'd3}));
        chk("t5_old_iy", 32'({use_internal_x, use_internal_y}), 32'b01);
        run_to(18, "t5b");
        step(1'b0, 3'd0, 3'd0, 3'd0);
        chk("t5_new_slot", 32'({slot_ch, slot_op}), 32'({3'd0, 2'd3}));
        chk("t5_new_ix", 32'({use_internal_x, use_internal_y}), 32'b10);

        // Asynchronous reset mid-frame
        run_to(14, "t6");
        step(1'b0, 3'd0, 3'd0, 3'd0);
        #2 rst = 1'b1;
        #1;
        chk_all_zero("arst");
        model_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        step(1'b0, 3'd0, 3'd0, 3'd0);
        chk("t6_zero", 32'(zero), 32'd1);
        chk("t6_s1", 32'(s1_enters), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
